seq_detector_param: RTL

// - Parametrised serial bit-pattern detector. Generalises the fixed 4-bit "1010" Mealy detector to:
//   - any pattern of length N;
//   - overlap or non-overlap matching;
//   - Mealy or Moore output timing;
//   - an input-valid qualifier;
//   - a saturating match counter with a synchronous clear.
// - Sits on a 1-bit serial data stream as a standalone pattern monitor.

---
 rtl/seq_detector_param.sv | 98 +++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector.
// Watches a 1-bit stream and flags every occurrence of PATTERN. The match can
// be reported in the same cycle (Mealy) or one cycle later (Moore). Overlap
// handling is selectable. A saturating counter tracks the number of matches.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous reset, active-high
//   en         x is valid and accepted this cycle
//   x          serial data bit (first bit received aligns with PATTERN MSB)
//   clr_cnt    synchronous clear of match_cnt; wins over a simultaneous match
//   y          match indication (combinational when MOORE=0, registered when MOORE=1)
//   match_cnt  saturating match count
module seq_detector_param #(
  parameter int unsigned N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1010,
  parameter bit          OVERLAP = 1'b1,
  parameter bit          MOORE   = 1'b0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned HW = N - 1;
  localparam int unsigned FW = (N > 2) ? $clog2(N) : 1;
  localparam logic [FW-1:0]    FILL_FULL = FW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [HW-1:0] hist;
  logic [HW-1:0] hist_nxt;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_nxt;
  logic          match_c;

  // Match term and next history/fill for an accepted bit
  always_comb begin
    match_c  = 1'b0;
    hist_nxt = hist;
    fill_nxt = fill;

    match_c = en && !rst && (fill == FILL_FULL) && ({hist, x} == PATTERN);

    // Keep the newest N-1 bits: dropping the MSB of {hist,x} also covers N=2.
    hist_nxt = HW'({hist, x});

    if (match_c && !OVERLAP) begin
      fill_nxt = '0;
    end else if (fill != FILL_FULL) begin
      fill_nxt = fill + FW'(1);
    end
  end

  // History, fill level and saturating match counter
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else begin
      if (en) begin
        hist <= hist_nxt;
        fill <= fill_nxt;
      end
      if (clr_cnt) begin
        match_cnt <= '0;
      end else if (match_c && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

  // Output timing selection
  generate
    if (MOORE) begin : g_moore
      logic y_q;

      // Registered match: high for the single cycle after the matching bit
      always_ff @(posedge clk) begin
        if (rst) begin
          y_q <= 1'b0;
        end else begin
          y_q <= match_c;
        end
      end

      assign y = y_q;
    end else begin : g_mealy
      assign y = match_c;
    end
  endgenerate

endmodule
